// File: rtl/rc4_pkg.sv
// Shared state and memory-owner encodings for the RC4 key-search controller.
package rc4_pkg;

    localparam int KEY_WIDTH_DEF = 24;

    localparam logic [1:0] MEM_NONE = 2'd0;
    localparam logic [1:0] MEM_INIT = 2'd1;
    localparam logic [1:0] MEM_KSA  = 2'd2;
    localparam logic [1:0] MEM_DEC  = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_INIT_GO   = 4'd1,
        ST_INIT_WAIT = 4'd2,
        ST_KSA_GO    = 4'd3,
        ST_KSA_WAIT  = 4'd4,
        ST_DEC_GO    = 4'd5,
        ST_DEC_WAIT  = 4'd6,
        ST_NEXT_KEY  = 4'd7,
        ST_HIT       = 4'd8,
        ST_MISS      = 4'd9,
        ST_STOP      = 4'd10
    } state_t;

endpackage

// File: rtl/rc4_key_search_ctrl_if.sv
// Engine-side bundle: S-memory owner select plus start/finish per engine.
interface rc4_key_search_ctrl_if;

    logic [1:0] mem_sel;
    logic       init_start;
    logic       init_finish;
    logic       ksa_start;
    logic       ksa_finish;
    logic       dec_start;
    logic       dec_finish;
    logic       dec_invalid;

    modport master (
        output mem_sel,
        output init_start,
        output ksa_start,
        output dec_start,
        input  init_finish,
        input  ksa_finish,
        input  dec_finish,
        input  dec_invalid
    );

    modport slave (
        input  mem_sel,
        input  init_start,
        input  ksa_start,
        input  dec_start,
        output init_finish,
        output ksa_finish,
        output dec_finish,
        output dec_invalid
    );

endinterface

// File: rtl/rc4_phase_handshake.sv
// One-shot start pulse and finish wait for the currently selected engine.
// Watchdog counter present only with RC4_SEARCH_WATCHDOG_EN defined.
module rc4_phase_handshake #(
    parameter int WDOG_CYCLES = 20000
) (
    input  logic clk,
    input  logic nreset,
    input  logic i_go,
    input  logic i_finish,
    output logic o_start,
    output logic o_done,
    output logic o_timeout
);

    logic r_start;
    logic r_busy;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_start <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_start <= i_go;
            if (i_go) begin
                r_busy <= 1'b1;
            end else if (o_done || o_timeout) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_start = r_start;
    assign o_done  = r_busy & i_finish;

`ifdef RC4_SEARCH_WATCHDOG_EN
    localparam int CW = $clog2(WDOG_CYCLES + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_cnt <= '0;
        end else if (i_go) begin
            r_cnt <= '0;
        end else if (r_busy && !i_finish) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Fires on the WDOG_CYCLES-th waiting cycle without a finish.
    assign o_timeout = r_busy & ~i_finish
                     & (r_cnt == CW'(WDOG_CYCLES - 1));
`else
    localparam int unused_wdog = WDOG_CYCLES;

    assign o_timeout = 1'b0;
`endif

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// RC4 key-search sequencer: S-init, KSA, decrypt for each candidate key.
// Optional per-phase watchdog enabled by defining RC4_SEARCH_WATCHDOG_EN.
module rc4_key_search_ctrl
    import rc4_pkg::*;
#(
    parameter int                   KEY_WIDTH   = KEY_WIDTH_DEF,
    parameter logic [KEY_WIDTH-1:0] KEY_LO      = '0,
    parameter logic [KEY_WIDTH-1:0] KEY_HI      = KEY_WIDTH'(24'h3FFFFF),
    parameter logic [KEY_WIDTH-1:0] KEY_STRIDE  = KEY_WIDTH'(1),
    parameter int                   WDOG_CYCLES = 20000
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 i_start,
    input  logic                 i_abort,
    output logic [KEY_WIDTH-1:0] o_key,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_found,
    output logic                 o_exhausted,
    output logic [KEY_WIDTH-1:0] o_keys_tried,
`ifdef RC4_SEARCH_WATCHDOG_EN
    output logic                 o_wdog_err,
`endif
    rc4_key_search_ctrl_if.master eng
);

    state_t               r_state;
    logic [KEY_WIDTH-1:0] r_key;
    logic [KEY_WIDTH-1:0] r_tried;
    logic [1:0]           r_mem_sel;
    logic                 r_found;
    logic                 r_exhausted;

    logic                 w_go;
    logic                 w_finish;
    logic                 w_hs_start;
    logic                 w_hs_done;
    logic                 w_hs_timeout;
    logic [KEY_WIDTH:0]   w_key_nxt;
    logic                 w_last_key;

    assign w_go = (r_state == ST_INIT_GO)
               || (r_state == ST_KSA_GO)
               || (r_state == ST_DEC_GO);

    // Only the engine that currently owns the memory can finish a phase.
    always_comb begin
        w_finish = 1'b0;
        unique case (r_mem_sel)
            MEM_INIT: w_finish = eng.init_finish;
            MEM_KSA:  w_finish = eng.ksa_finish;
            MEM_DEC:  w_finish = eng.dec_finish;
            default:  w_finish = 1'b0;
        endcase
    end

    rc4_phase_handshake #(
        .WDOG_CYCLES(WDOG_CYCLES)
    ) u_hs (
        .clk      (clk),
        .nreset   (nreset),
        .i_go     (w_go),
        .i_finish (w_finish),
        .o_start  (w_hs_start),
        .o_done   (w_hs_done),
        .o_timeout(w_hs_timeout)
    );

    // One extra bit so key + stride cannot wrap past KEY_HI.
    assign w_key_nxt  = {1'b0, r_key} + {1'b0, KEY_STRIDE};
    assign w_last_key = w_key_nxt > {1'b0, KEY_HI};

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state     <= ST_IDLE;
            r_key       <= '0;
            r_tried     <= '0;
            r_mem_sel   <= MEM_NONE;
            r_found     <= 1'b0;
            r_exhausted <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_key       <= KEY_LO;
                        r_tried     <= '0;
                        r_found     <= 1'b0;
                        r_exhausted <= 1'b0;
                        r_state     <= ST_INIT_GO;
                    end
                end
                ST_INIT_GO: begin
                    r_mem_sel <= MEM_INIT;
                    r_state   <= ST_INIT_WAIT;
                end
                ST_INIT_WAIT: begin
                    if (w_hs_done) begin
                        r_state <= i_abort ? ST_STOP : ST_KSA_GO;
                    end else if (w_hs_timeout) begin
                        r_state <= ST_STOP;
                    end
                end
                ST_KSA_GO: begin
                    r_mem_sel <= MEM_KSA;
                    r_state   <= ST_KSA_WAIT;
                end
                ST_KSA_WAIT: begin
                    if (w_hs_done) begin
                        r_state <= i_abort ? ST_STOP : ST_DEC_GO;
                    end else if (w_hs_timeout) begin
                        r_state <= ST_STOP;
                    end
                end
                ST_DEC_GO: begin
                    r_mem_sel <= MEM_DEC;
                    r_state   <= ST_DEC_WAIT;
                end
                ST_DEC_WAIT: begin
                    // A valid plaintext beats a concurrent abort.
                    if (w_hs_done) begin
                        if (!eng.dec_invalid) begin
                            r_state <= ST_HIT;
                        end else if (i_abort) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_state <= ST_NEXT_KEY;
                        end
                    end else if (w_hs_timeout) begin
                        r_state <= ST_STOP;
                    end
                end
                ST_NEXT_KEY: begin
                    r_tried <= r_tried + 1'b1;
                    if (w_last_key) begin
                        r_state <= ST_MISS;
                    end else begin
                        r_key   <= w_key_nxt[KEY_WIDTH-1:0];
                        r_state <= ST_INIT_GO;
                    end
                end
                ST_HIT: begin
                    r_tried   <= r_tried + 1'b1;
                    r_found   <= 1'b1;
                    r_mem_sel <= MEM_NONE;
                    r_state   <= ST_IDLE;
                end
                ST_MISS: begin
                    r_exhausted <= 1'b1;
                    r_mem_sel   <= MEM_NONE;
                    r_state     <= ST_IDLE;
                end
                ST_STOP: begin
                    r_mem_sel <= MEM_NONE;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_mem_sel <= MEM_NONE;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef RC4_SEARCH_WATCHDOG_EN
    logic r_wdog_err;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_wdog_err <= 1'b0;
        end else if (r_state == ST_IDLE && i_start) begin
            r_wdog_err <= 1'b0;
        end else if (w_hs_timeout) begin
            r_wdog_err <= 1'b1;
        end
    end

    assign o_wdog_err = r_wdog_err;
`endif

    // Start pulses are gated by reset so they drop in the reset cycle.
    assign eng.mem_sel    = r_mem_sel;
    assign eng.init_start = nreset & w_hs_start & (r_mem_sel == MEM_INIT);
    assign eng.ksa_start  = nreset & w_hs_start & (r_mem_sel == MEM_KSA);
    assign eng.dec_start  = nreset & w_hs_start & (r_mem_sel == MEM_DEC);

    assign o_key        = r_key;
    assign o_keys_tried = r_tried;
    assign o_found      = r_found;
    assign o_exhausted  = r_exhausted;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_done       = (r_state == ST_HIT)
                       || (r_state == ST_MISS)
                       || (r_state == ST_STOP);

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Bench: two controllers (keys 0..3 and 5..7) driven by random-latency engines.
// Watchdog scenario runs when RC4_SEARCH_WATCHDOG_EN is defined.
module tb_rc4_key_search_ctrl;
    import rc4_pkg::*;

    localparam int W  = 24;
    localparam int WD = 10;

    logic              clk;
    logic              nreset;
    logic [1:0]        start;
    logic [1:0]        abort;
    logic [1:0][W-1:0] key;
    logic [1:0][W-1:0] tried;
    logic [1:0]        busy, done, found, exh;
`ifdef RC4_SEARCH_WATCHDOG_EN
    logic [1:0]        wdog;
`endif
    logic [1:0]        st_i, st_k, st_d;
    logic [1:0]        fin_i, fin_k, fin_d, dinv;
    logic [1:0][1:0]   msel;
    logic [W-1:0]      good [2];
    logic [1:0]        hold_init;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        localparam logic [W-1:0] LO = (g == 0) ? W'(0) : W'(5);
        localparam logic [W-1:0] HI = (g == 0) ? W'(3) : W'(7);

        rc4_key_search_ctrl_if eng_if ();

        rc4_key_search_ctrl #(
            .KEY_WIDTH  (W),
            .KEY_LO     (LO),
            .KEY_HI     (HI),
            .KEY_STRIDE (W'(1)),
            .WDOG_CYCLES(WD)
        ) u_dut (
            .clk         (clk),
            .nreset      (nreset),
            .i_start     (start[g]),
            .i_abort     (abort[g]),
            .o_key       (key[g]),
            .o_busy      (busy[g]),
            .o_done      (done[g]),
            .o_found     (found[g]),
            .o_exhausted (exh[g]),
            .o_keys_tried(tried[g]),
`ifdef RC4_SEARCH_WATCHDOG_EN
            .o_wdog_err  (wdog[g]),
`endif
            .eng         (eng_if.master)
        );

        assign st_i[g] = eng_if.init_start;
        assign st_k[g] = eng_if.ksa_start;
        assign st_d[g] = eng_if.dec_start;
        assign msel[g] = eng_if.mem_sel;
        assign eng_if.init_finish = fin_i[g];
        assign eng_if.ksa_finish  = fin_k[g];
        assign eng_if.dec_finish  = fin_d[g];
        assign eng_if.dec_invalid = dinv[g];
    end

    // Engine model: finish a random 1..5 cycles after each start.
    logic [1:0] e_act;
    int         e_ph  [2];
    int         e_dly [2];

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            fin_i[g] <= 1'b0;
            fin_k[g] <= 1'b0;
            fin_d[g] <= 1'b0;
            dinv[g]  <= 1'b0;
            if (!nreset) begin
                e_act[g] <= 1'b0;
            end else if (st_i[g] || st_k[g] || st_d[g]) begin
                e_act[g] <= 1'b1;
                e_ph[g]  <= st_i[g] ? 1 : (st_k[g] ? 2 : 3);
                e_dly[g] <= int'($urandom_range(0, 4));
            end else if (e_act[g] && !(e_ph[g] == 1 && hold_init[g])) begin
                if (e_dly[g] == 0) begin
                    e_act[g] <= 1'b0;
                    if (e_ph[g] == 1) fin_i[g] <= 1'b1;
                    else if (e_ph[g] == 2) fin_k[g] <= 1'b1;
                    else begin
                        fin_d[g] <= 1'b1;
                        dinv[g]  <= (key[g] != good[g]);
                    end
                end else begin
                    e_dly[g] <= e_dly[g] - 1;
                end
            end
        end
    end

    // Protocol observers: pulse widths, owner select, event counts.
    int         viol_w [2] = '{0, 0};
    int         viol_s [2] = '{0, 0};
    int         n_done [2] = '{0, 0};
    int         n_init [2] = '{0, 0};
    int         n_dec  [2] = '{0, 0};
    logic [1:0] p_i = '0, p_k = '0, p_d = '0, m_act = '0;
    logic [1:0] m_sel [2];

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!nreset) begin
                m_act[g] = 1'b0;
            end else begin
                if ((st_i[g] && p_i[g]) || (st_k[g] && p_k[g])
                    || (st_d[g] && p_d[g])) viol_w[g]++;
                if ((st_i[g] && msel[g] != MEM_INIT)
                    || (st_k[g] && msel[g] != MEM_KSA)
                    || (st_d[g] && msel[g] != MEM_DEC)) viol_s[g]++;
                if (st_i[g] || st_k[g] || st_d[g]) begin
                    m_act[g] = 1'b1;
                    m_sel[g] = msel[g];
                end else if (m_act[g]) begin
                    if (msel[g] != m_sel[g]) viol_s[g]++;
                    if (fin_i[g] || fin_k[g] || fin_d[g] || done[g])
                        m_act[g] = 1'b0;
                end
                if (done[g]) n_done[g]++;
                if (st_i[g]) n_init[g]++;
                if (st_d[g]) n_dec[g]++;
            end
            p_i[g] = st_i[g];
            p_k[g] = st_k[g];
            p_d[g] = st_d[g];
        end
    end

    // Reference: walk the key range by the rules, stop on hit or range end.
    function automatic void ref_search(input int lo, input int hi,
                                       input int stride, input int gk,
                                       output int k, output int n,
                                       output bit f, output bit x);
        bit fin;
        k = lo; n = 0; f = 1'b0; x = 1'b0; fin = 1'b0;
        while (!fin) begin
            n++;
            if (k == gk) begin
                f = 1'b1; fin = 1'b1;
            end else if (k + stride > hi) begin
                x = 1'b1; fin = 1'b1;
            end else begin
                k += stride;
            end
        end
    endfunction

    task automatic pulse_start(input int g);
        @(negedge clk);
        start[g] = 1'b1;
        @(negedge clk);
        start[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 600 && !ok; c++) begin
            @(negedge clk);
            if (done[g]) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (key[g] !== '0 || tried[g] !== '0) begin
                errors++;
                $display("FAIL reset_key_tried[%0d]: got %0h/%0h required 0/0", g, key[g], tried[g]);
            end
            checks++;
            if ({busy[g], done[g], found[g], exh[g]} !== 4'b0) begin
                errors++;
                $display("FAIL reset_flags[%0d]: got %b required 0000", g, {busy[g], done[g], found[g], exh[g]});
            end
            checks++;
            if (msel[g] !== MEM_NONE || {st_i[g], st_k[g], st_d[g]} !== 3'b0) begin
                errors++;
                $display("FAIL reset_eng[%0d]: sel %0d starts %b required 0 000", g, msel[g], {st_i[g], st_k[g], st_d[g]});
            end
        end
        nreset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_hit();
        bit ok;
        int nd0, ni0, nq0;
        good[0] = W'(2);
        nd0 = n_done[0]; ni0 = n_init[0]; nq0 = n_dec[0];
        pulse_start(0);
        wait_done(0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL hit_done: got timeout required done"); end
        repeat (3) @(negedge clk);
        checks++;
        if (found[0] !== 1'b1 || exh[0] !== 1'b0) begin
            errors++;
            $display("FAIL hit_flags: found %b exh %b required 1 0", found[0], exh[0]);
        end
        checks++;
        if (key[0] !== W'(2) || tried[0] !== W'(3)) begin
            errors++;
            $display("FAIL hit_key: key %0d tried %0d required 2 3", key[0], tried[0]);
        end
        checks++;
        if (n_done[0] - nd0 != 1) begin
            errors++;
            $display("FAIL hit_done_count: got %0d required 1", n_done[0] - nd0);
        end
        checks++;
        if (n_init[0] - ni0 != 3 || n_dec[0] - nq0 != 3) begin
            errors++;
            $display("FAIL hit_runs: init %0d dec %0d required 3 3", n_init[0] - ni0, n_dec[0] - nq0);
        end
        checks++;
        if (msel[0] !== MEM_NONE || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL hit_idle: sel %0d busy %b required 0 0", msel[0], busy[0]);
        end
    endtask

    task automatic test_miss();
        bit ok;
        int nd0;
        good[1] = W'(99);
        nd0 = n_done[1];
        pulse_start(1);
        wait_done(1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL miss_done: got timeout required done"); end
        repeat (3) @(negedge clk);
        checks++;
        if (exh[1] !== 1'b1 || found[1] !== 1'b0) begin
            errors++;
            $display("FAIL miss_flags: exh %b found %b required 1 0", exh[1], found[1]);
        end
        checks++;
        if (key[1] !== W'(7) || tried[1] !== W'(3)) begin
            errors++;
            $display("FAIL miss_key: key %0d tried %0d required 7 3", key[1], tried[1]);
        end
        checks++;
        if (msel[1] !== MEM_NONE || n_done[1] - nd0 != 1) begin
            errors++;
            $display("FAIL miss_end: sel %0d dones %0d required 0 1", msel[1], n_done[1] - nd0);
        end
    endtask

    task automatic test_random();
        bit ok, ef, ex;
        int gk, ek, en;
        for (int it = 0; it < 6; it++) begin
            gk = int'($urandom_range(0, 5));
            good[0] = W'(gk);
            ref_search(0, 3, 1, gk, ek, en, ef, ex);
            pulse_start(0);
            wait_done(0, ok);
            @(negedge clk);
            checks++;
            if (!ok || key[0] !== W'(ek) || tried[0] !== W'(en)
                || found[0] !== ef || exh[0] !== ex) begin
                errors++;
                $display("FAIL rand_search good=%0d: key %0d tried %0d f %b x %b required %0d %0d %b %b",
                         gk, key[0], tried[0], found[0], exh[0], ek, en, ef, ex);
            end
        end
    endtask

    task automatic test_abort();
        bit ok, seen;
        int nq0;
        good[0] = W'(99);
        nq0 = n_dec[0];
        seen = 1'b0;
        pulse_start(0);
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (st_k[0]) seen = 1'b1;
        end
        abort[0] = 1'b1;
        wait_done(0, ok);
        abort[0] = 1'b0;
        checks++;
        if (!seen || !ok) begin errors++; $display("FAIL abort_seq: ksa %b done %b required 1 1", seen, ok); end
        @(negedge clk);
        checks++;
        if (found[0] !== 1'b0 || exh[0] !== 1'b0 || key[0] !== '0 || tried[0] !== '0) begin
            errors++;
            $display("FAIL abort_state: f %b x %b key %0d tried %0d required 0 0 0 0", found[0], exh[0], key[0], tried[0]);
        end
        checks++;
        if (n_dec[0] != nq0 || msel[0] !== MEM_NONE) begin
            errors++;
            $display("FAIL abort_no_dec: dec starts %0d sel %0d required 0 0", n_dec[0] - nq0, msel[0]);
        end
    endtask

    task automatic test_hit_abort();
        bit ok, seen;
        good[0] = W'(0);
        seen = 1'b0;
        pulse_start(0);
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (st_d[0]) seen = 1'b1;
        end
        abort[0] = 1'b1;
        wait_done(0, ok);
        abort[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (!ok || found[0] !== 1'b1 || key[0] !== '0 || tried[0] !== W'(1)) begin
            errors++;
            $display("FAIL hit_vs_abort: f %b key %0d tried %0d required 1 0 1", found[0], key[0], tried[0]);
        end
    endtask

    task automatic test_start_busy();
        bit ok, seen, ef, ex;
        int ek, en;
        good[0] = W'(99);
        ref_search(0, 3, 1, 99, ek, en, ef, ex);
        seen = 1'b0;
        pulse_start(0);
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (key[0] == W'(1)) seen = 1'b1;
        end
        pulse_start(0);
        checks++;
        if (!seen || key[0] !== W'(1) || tried[0] !== W'(1) || busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL start_busy: key %0d tried %0d busy %b required 1 1 1", key[0], tried[0], busy[0]);
        end
        wait_done(0, ok);
        @(negedge clk);
        checks++;
        if (!ok || key[0] !== W'(ek) || tried[0] !== W'(en) || exh[0] !== ex) begin
            errors++;
            $display("FAIL start_busy_end: key %0d tried %0d x %b required %0d %0d %b", key[0], tried[0], exh[0], ek, en, ex);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        good[0] = W'(99);
        seen = 1'b0;
        pulse_start(0);
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (st_d[0] && key[0] == W'(1)) seen = 1'b1;
        end
        nreset = 1'b0;
        #1;
        checks++;
        if (!seen || st_d[0] !== 1'b0) begin
            errors++;
            $display("FAIL rst_start_drop: seen %b dec_start %b required 1 0", seen, st_d[0]);
        end
        @(negedge clk);
        checks++;
        if (key[0] !== '0 || tried[0] !== '0 || msel[0] !== MEM_NONE
            || {busy[0], done[0], found[0], exh[0]} !== 4'b0) begin
            errors++;
            $display("FAIL rst_mid: key %0d tried %0d sel %0d flags %b required 0 0 0 0000",
                     key[0], tried[0], msel[0], {busy[0], done[0], found[0], exh[0]});
        end
        nreset = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (busy[0] !== 1'b0 || st_i[0] !== 1'b0) begin
            errors++;
            $display("FAIL rst_stays_idle: busy %b init_start %b required 0 0", busy[0], st_i[0]);
        end
    endtask

    task automatic test_handshake();
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (viol_w[g] != 0) begin
                errors++;
                $display("FAIL start_width[%0d]: got %0d wide pulses required 0", g, viol_w[g]);
            end
            checks++;
            if (viol_s[g] != 0) begin
                errors++;
                $display("FAIL mem_sel[%0d]: got %0d bad selects required 0", g, viol_s[g]);
            end
        end
    endtask

`ifdef RC4_SEARCH_WATCHDOG_EN
    task automatic test_watchdog();
        bit ok, seen, hit;
        int c;
        good[0] = W'(1);
        hold_init[0] = 1'b1;
        seen = 1'b0;
        hit = 1'b0;
        c = 0;
        pulse_start(0);
        for (int i = 0; i < 20 && !seen; i++) begin
            if (st_i[0]) seen = 1'b1;
            else @(negedge clk);
        end
        while (!hit && c < 60) begin
            @(negedge clk);
            c++;
            if (done[0]) hit = 1'b1;
        end
        checks++;
        if (!seen || !hit || c != WD) begin
            errors++;
            $display("FAIL wdog_latency: got %0d cycles required %0d", c, WD);
        end
        checks++;
        if (wdog[0] !== 1'b1 || found[0] !== 1'b0 || exh[0] !== 1'b0) begin
            errors++;
            $display("FAIL wdog_flags: err %b f %b x %b required 1 0 0", wdog[0], found[0], exh[0]);
        end
        hold_init[0] = 1'b0;
        pulse_start(0);
        checks++;
        if (wdog[0] !== 1'b0) begin errors++; $display("FAIL wdog_clear: got %b required 0", wdog[0]); end
        wait_done(0, ok);
        @(negedge clk);
        checks++;
        if (!ok || found[0] !== 1'b1 || key[0] !== W'(1)) begin
            errors++;
            $display("FAIL wdog_recover: f %b key %0d required 1 1", found[0], key[0]);
        end
    endtask
`endif

    initial begin
        nreset    = 1'b0;
        start     = '0;
        abort     = '0;
        hold_init = '0;
        good[0]   = W'(99);
        good[1]   = W'(99);
        test_reset();
        test_hit();
        test_miss();
        test_random();
        test_abort();
        test_hit_abort();
        test_start_busy();
        test_reset_mid();
        test_handshake();
`ifdef RC4_SEARCH_WATCHDOG_EN
        test_watchdog();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rc4_key_search_ctrl.md
Name: rc4_key_search_ctrl

Overview:
- Top-level sequencer for one RC4 cracking core.
- For each candidate key it runs three engines in order on the shared S-memory: S-init (s[i]=i), KSA shuffle, then the decrypt engine.
- The decrypt engine reports valid or invalid plaintext. The controller stops on the first valid key, or when the key range is exhausted.
- It also drives the S-memory owner select for the external memory mux.

Parameters:
- KEY_WIDTH, 24, candidate key width in bits.
- KEY_LO, 0, first key tried.
- KEY_HI, 24'h3FFFFF, last key tried (inclusive).
- KEY_STRIDE, 1, increment between keys (set to N for N interleaved cores).
- WDOG_CYCLES, 20000, per-phase cycle budget (used only with the watchdog feature).

Ports:
- clk  in  1  clock
- nreset  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; begins a search from KEY_LO
- abort  in  1  level; stops the search at the next state boundary
- key  out  KEY_WIDTH  current candidate key, fed to the KSA engine
- mem_sel  out  2  S-memory owner: 0 none, 1 init, 2 ksa, 3 decrypt
- init_start  out  1  one-cycle start pulse to the S-init engine
- init_finish  in  1  one-cycle done pulse from the S-init engine
- ksa_start  out  1  one-cycle start pulse to the KSA engine
- ksa_finish  in  1  one-cycle done pulse from the KSA engine
- dec_start  out  1  one-cycle start pulse to the decrypt engine
- dec_finish  in  1  decrypt done pulse
- dec_invalid  in  1  sampled with dec_finish; 1 = plaintext invalid
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle pulse at search end
- found  out  1  sticky: valid key found; cleared on start
- exhausted  out  1  sticky: range exhausted with no valid key; cleared on start
- keys_tried  out  KEY_WIDTH  number of candidates completed

Behaviour:
- Reset (nreset=0 at posedge clk):
  - State IDLE.
  - All outputs 0 (key, mem_sel, starts, busy, done, found, exhausted, keys_tried).
  - Reset mid-search abandons the search immediately; engine start pulses drop the same cycle.
- States: IDLE, INIT_GO, INIT_WAIT, KSA_GO, KSA_WAIT, DEC_GO, DEC_WAIT, NEXT_KEY, HIT, MISS, STOP.
- IDLE
  - On start: key<=KEY_LO, found<=0, exhausted<=0, keys_tried<=0, go to INIT_GO.
  - start outside IDLE is ignored.
- INIT_GO
  - mem_sel<=1, init_start=1 for exactly one cycle, then INIT_WAIT.
  - mem_sel changes only in *_GO states, so it is stable before each start pulse.
- INIT_WAIT: on init_finish go to KSA_GO.
- KSA_GO / KSA_WAIT: same pattern as init, with mem_sel=2. On ksa_finish go to DEC_GO.
- DEC_GO / DEC_WAIT: same pattern, with mem_sel=3. On dec_finish:
  - dec_invalid=0: go to HIT.
  - dec_invalid=1: go to NEXT_KEY.
- In any state, a done pulse arriving while not in the matching WAIT state is ignored.
- NEXT_KEY
  - keys_tried+1.
  - If key > KEY_HI-KEY_STRIDE (compare at KEY_WIDTH+1 bits, no wrap), go to MISS.
  - Otherwise key<=key+KEY_STRIDE and go to INIT_GO.
- HIT
  - keys_tried+1, found<=1, key held at the winning value, mem_sel<=0, done=1, then IDLE.
- MISS
  - exhausted<=1, mem_sel<=0, done=1, then IDLE.
  - key holds the last key tried.
- abort
  - Sampled only in *_WAIT states, after the matching finish arrives, so an engine is never cut off mid-write.
  - Instead of advancing, go to STOP: mem_sel<=0, done=1, found=0, exhausted=0, then IDLE.
- Simultaneous dec_finish with dec_invalid=0 and abort: HIT wins.
- KEY_LO==KEY_HI: exactly one key is tried.
- Latency per key: 3 engine runs plus 7 controller cycles.

Optional Feature:
- Macro RC4_SEARCH_WATCHDOG_EN.
- When defined:
  - A counter runs in each *_WAIT state and resets on entry to each *_GO state.
  - When it reaches WDOG_CYCLES without the expected finish, go to STOP and set extra output wdog_err (sticky, cleared on start).
- When not defined: no counter, no wdog_err port; WAIT states wait indefinitely.

Decomposition:
- Package rc4_pkg holds:
  - state enum typedef;
  - mem_sel encodings MEM_NONE/MEM_INIT/MEM_KSA/MEM_DEC;
  - default KEY_WIDTH.
- One natural sub-module: rc4_phase_handshake. It turns a go request into a one-cycle start pulse and waits for finish (plus the watchdog when enabled). It is instantiated once and reused per phase via mem_sel.

Test Plan:
- KEY_LO=0, KEY_HI=3; the dec model returns invalid for keys 0,1 and valid for key 2 -> found=1, key=2, keys_tried=3, one done pulse, exhausted=0.
- KEY_LO=5, KEY_HI=7; every decrypt invalid -> exhausted=1, found=0, key=7, keys_tried=3, mem_sel=0 after done.
- Check starts and mem_sel:
  - Each start pulse is exactly 1 cycle wide.
  - mem_sel is 1, 2, 3 before init_start, ksa_start, dec_start respectively, and never changes inside a WAIT state.
- abort raised in KSA_WAIT for key 0 -> ksa finishes, then STOP with done=1, found=0, exhausted=0; no dec_start issued.
- Assert nreset low during DEC_WAIT, and separately pulse start while busy:
  - Reset -> all outputs 0 next cycle.
  - start while busy -> ignored (key unchanged).
- With RC4_SEARCH_WATCHDOG_EN defined and WDOG_CYCLES=10, init_finish withheld -> wdog_err=1 and done pulse 10 cycles after entering INIT_WAIT.
